// File: rtl/path_replay.sv
// path_replay: turns the solver's move list into a stream of absolute (x,y) coordinates, starting at the origin.
// Build option: define PATH_REPLAY_BOUNDS_CHECK_EN to stop with error on an off-grid move instead of wrapping.
module path_replay #(
  parameter int N              = 4,
  parameter int DIRECTION_SIZE = 2,
  parameter int STEP_W         = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      start,
  input  logic [DIRECTION_SIZE-1:0] Move,
  input  logic                      complete_read,
  output logic                      en_read,
  output logic [N-1:0]              pos_x,
  output logic [N-1:0]              pos_y,
  output logic                      pos_valid,
  input  logic                      pos_ready,
  output logic [STEP_W-1:0]         steps,
  output logic                      busy,
  output logic                      done,
  output logic                      at_goal,
  output logic                      error
);

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    FETCH,
    FINISH
  } state_t;

`ifdef PATH_REPLAY_BOUNDS_CHECK_EN
  localparam bit BOUNDS_CHECK = 1'b1;
`else
  localparam bit BOUNDS_CHECK = 1'b0;
`endif

  localparam logic [DIRECTION_SIZE-1:0] MOVE_UP    = DIRECTION_SIZE'(0);
  localparam logic [DIRECTION_SIZE-1:0] MOVE_RIGHT = DIRECTION_SIZE'(1);
  localparam logic [DIRECTION_SIZE-1:0] MOVE_LEFT  = DIRECTION_SIZE'(2);
  localparam logic [N-1:0]              COORD_ONE  = N'(1);
  localparam logic [N-1:0]              COORD_MAX  = '1;
  localparam logic [STEP_W-1:0]         STEP_ONE   = STEP_W'(1);
  localparam logic [STEP_W-1:0]         STEP_MAX   = '1;

  state_t              state_reg, state_next;
  logic [N-1:0]        pos_x_reg, pos_x_next;
  logic [N-1:0]        pos_y_reg, pos_y_next;
  logic [STEP_W-1:0]   steps_reg, steps_next;
  logic                error_reg, error_next;

  logic [N-1:0]        moved_x, moved_y;
  logic                move_off_grid;

  // Candidate position for the current move code; wraps naturally in N bits.
  always_comb begin
    moved_x       = pos_x_reg;
    moved_y       = pos_y_reg;
    move_off_grid = 1'b0;
    case (Move)
      MOVE_UP: begin
        moved_y       = pos_y_reg - COORD_ONE;
        move_off_grid = (pos_y_reg == '0);
      end
      MOVE_RIGHT: begin
        moved_x       = pos_x_reg + COORD_ONE;
        move_off_grid = (pos_x_reg == COORD_MAX);
      end
      MOVE_LEFT: begin
        moved_x       = pos_x_reg - COORD_ONE;
        move_off_grid = (pos_x_reg == '0);
      end
      default: begin
        moved_y       = pos_y_reg + COORD_ONE;
        move_off_grid = (pos_y_reg == COORD_MAX);
      end
    endcase
  end

  always_comb begin
    state_next = state_reg;
    pos_x_next = pos_x_reg;
    pos_y_next = pos_y_reg;
    steps_next = steps_reg;
    error_next = error_reg;
    en_read    = 1'b0;
    case (state_reg)
      IDLE, FINISH: begin
        if (start) begin
          state_next = EMIT;
          pos_x_next = '0;
          pos_y_next = '0;
          steps_next = '0;
          error_next = 1'b0;
        end
      end
      EMIT: begin
        if (pos_ready) begin
          state_next = FETCH;
        end
      end
      FETCH: begin
        if (complete_read) begin
          state_next = FINISH;
        end else if (BOUNDS_CHECK && move_off_grid) begin
          // Rejected move: keep the position and leave the list untouched.
          error_next = 1'b1;
          state_next = FINISH;
        end else begin
          en_read    = 1'b1;
          pos_x_next = moved_x;
          pos_y_next = moved_y;
          steps_next = (steps_reg == STEP_MAX) ? steps_reg : steps_reg + STEP_ONE;
          state_next = EMIT;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg <= IDLE;
      pos_x_reg <= '0;
      pos_y_reg <= '0;
      steps_reg <= '0;
      error_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      pos_x_reg <= pos_x_next;
      pos_y_reg <= pos_y_next;
      steps_reg <= steps_next;
      error_reg <= error_next;
    end
  end

  assign pos_x     = pos_x_reg;
  assign pos_y     = pos_y_reg;
  assign steps     = steps_reg;
  assign pos_valid = (state_reg == EMIT);
  assign busy      = (state_reg == EMIT) || (state_reg == FETCH);
  assign done      = (state_reg == FINISH);
  assign at_goal   = (state_reg == FINISH) && (&{pos_x_reg, pos_y_reg});
  assign error     = BOUNDS_CHECK ? error_reg : 1'b0;

endmodule

// File: tb/tb_path_replay.sv
// tb_path_replay: random and directed move lists replayed through path_replay, checked against a coordinate-level model.
// Honours PATH_REPLAY_BOUNDS_CHECK_EN the same way the design does.
module tb_path_replay;

  localparam int N      = 4;
  localparam int DW     = 2;
  localparam int SW     = 8;
  localparam int GRID   = 1 << N;
  localparam int SMAX   = (1 << SW) - 1;
  localparam int MAXLEN = 512;

  logic          CLK = 1'b0;
  logic          RST;
  logic          start;
  logic [DW-1:0] Move;
  logic          complete_read;
  logic          en_read;
  logic [N-1:0]  pos_x, pos_y;
  logic          pos_valid;
  logic          pos_ready;
  logic [SW-1:0] steps;
  logic          busy, done, at_goal, error;

  logic [DW-1:0] mem [MAXLEN];
  int total = 0;
  int bad   = 0;

  path_replay #(.N(N), .DIRECTION_SIZE(DW), .STEP_W(SW)) dut (
    .CLK(CLK), .RST(RST), .start(start), .Move(Move), .complete_read(complete_read),
    .en_read(en_read), .pos_x(pos_x), .pos_y(pos_y), .pos_valid(pos_valid),
    .pos_ready(pos_ready), .steps(steps), .busy(busy), .done(done),
    .at_goal(at_goal), .error(error)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk(tag, {10'd0, en_read, pos_valid, busy, done, at_goal, error, pos_x, pos_y, steps}, 32'd0);
  endtask

  // Replays mem[0:len-1]; ready mode 0=always, 1=toggle, 2=random. abort_after>0 resets after that many reads.
  task automatic run_path(input int len, input int mode, input int abort_after);
    int ex = 0;
    int ey = 0;
    int n_ok = 0;
    bit eerr = 1'b0;
    logic [2*N-1:0] exp_q[$];
    logic [2*N-1:0] got_q[$];
    logic [2*N-1:0] held = '0;
    int rd_idx = 0;
    int en_cnt = 0;
    bit pend = 1'b0;
    bit prev_en = 1'b0;
    bit was_stall = 1'b0;
    bit finished = 1'b0;
    int n_cmp;

    // Reference: walk the grid with plain integers.
    exp_q.push_back('0);
    for (int i = 0; i < len; i++) begin
      int nx = ex;
      int ny = ey;
      case (mem[i])
        2'd0: ny = ny - 1;
        2'd1: nx = nx + 1;
        2'd2: nx = nx - 1;
        default: ny = ny + 1;
      endcase
      if (nx < 0 || nx >= GRID || ny < 0 || ny >= GRID) begin
`ifdef PATH_REPLAY_BOUNDS_CHECK_EN
        eerr = 1'b1;
        break;
`else
        nx = (nx + GRID) % GRID;
        ny = (ny + GRID) % GRID;
`endif
      end
      ex = nx;
      ey = ny;
      n_ok++;
      exp_q.push_back({ex[N-1:0], ey[N-1:0]});
    end

    @(negedge CLK);
    complete_read = (len == 0);
    Move = (len > 0) ? mem[0] : '0;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    for (int cyc = 0; cyc < len * 8 + 40; cyc++) begin
      // The list advances on the edge that ends the en_read cycle.
      if (pend) rd_idx++;
      pend = 1'b0;
      complete_read = (rd_idx >= len);
      Move = (rd_idx < len) ? mem[rd_idx] : '0;
      case (mode)
        0: pos_ready = 1'b1;
        1: pos_ready = cyc[0];
        default: pos_ready = 1'($urandom % 2);
      endcase
      #1;
      if (was_stall) chk("hold", {23'd0, pos_valid, pos_x, pos_y}, {23'd0, 1'b1, held});
      if (en_read) begin
        chk("en_gap", {31'd0, prev_en}, 32'd0);
        en_cnt++;
        pend = 1'b1;
      end
      prev_en = en_read;
      was_stall = pos_valid && !pos_ready;
      held = {pos_x, pos_y};
      if (pos_valid && pos_ready) got_q.push_back({pos_x, pos_y});
      if (abort_after > 0 && en_cnt == abort_after) begin
        #2 RST = 1'b0;
        #1 chk_reset_vals("rst_async");
        @(negedge CLK);
        chk_reset_vals("rst_hold");
        RST = 1'b1;
        @(negedge CLK);
        chk_reset_vals("rst_release");
        $display("abort len=%0d after %0d reads coords=%0d", len, en_cnt, got_q.size());
        return;
      end
      if (done) begin
        finished = 1'b1;
        break;
      end
      @(negedge CLK);
    end

    chk("finished", {31'd0, finished}, 32'd1);
    chk("n_coords", got_q.size(), exp_q.size());
    n_cmp = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n_cmp; i++) chk($sformatf("coord%0d", i), {24'd0, got_q[i]}, {24'd0, exp_q[i]});
    chk("steps", {24'd0, steps}, (n_ok > SMAX) ? SMAX : n_ok);
    chk("at_goal", {31'd0, at_goal}, {31'd0, (ex == GRID - 1 && ey == GRID - 1)});
    chk("error", {31'd0, error}, {31'd0, eerr});
    chk("en_cnt", en_cnt, n_ok);
    chk("idle_flags", {30'd0, busy, pos_valid}, 32'd0);
    $display("run len=%0d mode=%0d coords=%0d steps=%0d goal=%0b err=%0b reads=%0d",
             len, mode, got_q.size(), steps, at_goal, error, en_cnt);
  endtask

  initial begin
    int len;
    RST = 1'b0;
    start = 1'b0;
    complete_read = 1'b1;
    pos_ready = 1'b0;
    Move = '0;
    repeat (3) @(negedge CLK);
    chk_reset_vals("reset");
    RST = 1'b1;

    for (int i = 0; i < 15; i++) mem[i] = 2'd1;
    for (int i = 15; i < 30; i++) mem[i] = 2'd3;
    run_path(30, 0, 0);

    mem[0] = 2'd1; mem[1] = 2'd3; mem[2] = 2'd1; mem[3] = 2'd3;
    run_path(4, 1, 0);

    run_path(0, 0, 0);

    mem[0] = 2'd0; mem[1] = 2'd1;
    run_path(2, 0, 0);

    for (int i = 0; i < 300; i++) mem[i] = 2'($urandom % 4);
    run_path(300, 0, 0);

    repeat (8) begin
      len = $urandom_range(0, 40);
      for (int i = 0; i < len; i++) mem[i] = 2'($urandom % 4);
      run_path(len, $urandom_range(0, 2), 0);
    end

    for (int i = 0; i < 10; i++) mem[i] = 2'd1;
    run_path(10, 0, 3);
    for (int i = 0; i < 5; i++) mem[i] = 2'($urandom % 4);
    run_path(5, 2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/path_replay.md
# path_replay

Downstream consumer of the maze solver's result list. After a solve completes, it reads the stored direction codes one at a time and rebuilds the absolute path as a stream of (X, Y) coordinates, starting at the origin. Each coordinate is offered over a valid/ready handshake to a display or checker stage. It also reports the step count and whether the path ends at the goal cell (all-ones corner).

## Interface
Parameters:
- N, 4, coordinate width; grid is 2^N x 2^N.
- DIRECTION_SIZE, 2, width of one move code.
- STEP_W, 8, width of step counter; saturates at all-ones.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  reset; one clock, reset is asynchronous and active-low.
- start  input  1  one-cycle pulse; begins replay when idle.
- Move  input  DIRECTION_SIZE  move code at the list's current read position.
- complete_read  input  1  list has no further entries to read.
- en_read  output  1  one-cycle pulse; advances the list read position.
- pos_x  output  N  emitted X coordinate.
- pos_y  output  N  emitted Y coordinate.
- pos_valid  output  1  pos_x/pos_y hold a valid coordinate.
- pos_ready  input  1  consumer accepts the coordinate.
- steps  output  STEP_W  moves consumed so far.
- busy  output  1  replay in progress.
- done  output  1  replay finished; held until the next start.
- at_goal  output  1  valid with done; final position is (2^N-1, 2^N-1).
- error  output  1  valid with done; bounds violation (see Configuration).

## Operation
- Move encoding: 00 = up (Y-1), 01 = right (X+1), 10 = left (X-1), 11 = down (Y+1).
- States: IDLE, EMIT, FETCH, FINISH.
- IDLE:
  - On start: clear the position registers to (0,0), steps to 0, and done, at_goal and error.
  - Go to EMIT.
  - start is ignored in every state except IDLE and FINISH.
- EMIT:
  - pos_valid=1 and the outputs show the current position.
  - On pos_valid && pos_ready: go to FETCH.
  - pos_x/pos_y are stable while stalled.
- FETCH:
  - If complete_read=1: go to FINISH; no en_read is issued.
  - Otherwise:
    - Sample Move and pulse en_read for this cycle only.
    - Update the position by the move code, N-bit arithmetic.
    - Increment steps, saturating.
    - Go to EMIT.
- FINISH:
  - done=1, busy=0, pos_valid=0.
  - at_goal = &{pos_x, pos_y}.
  - A new start restarts exactly as from IDLE.
- busy=1 in EMIT and FETCH.

## Timing
- Reset values:
  - State IDLE.
  - pos_x=0, pos_y=0, steps=0.
  - en_read=0, pos_valid=0, busy=0, done=0, at_goal=0, error=0.
- Reset is asserted asynchronously. It is released synchronously, and the FSM leaves IDLE no earlier than the first clock edge after release.
- start to first pos_valid: 1 cycle. The first coordinate is always (0,0).
- Each move costs one FETCH cycle plus at least one EMIT cycle. With pos_ready held at 1, a new coordinate is emitted every 2 cycles.
- en_read is never high in two consecutive cycles.
- Move is sampled in the same cycle that en_read is high. The list updates Move on the following edge.
- Empty list (complete_read=1 at the first FETCH):
  - Only (0,0) is emitted; steps=0.
  - at_goal=0 unless N=0.
- pos_ready may be high while pos_valid=0; this has no effect.
- RST asserted mid-replay aborts immediately to the reset values. The list is not rewound by this block.

## Configuration
- Macro: PATH_REPLAY_BOUNDS_CHECK_EN.
- Defined:
  - A move that would take X or Y below 0 or above 2^N-1 sets error=1.
  - The position is not updated and no en_read is issued.
  - The FSM goes directly to FINISH; at_goal is still evaluated on the unchanged position.
- Undefined:
  - Coordinates wrap modulo 2^N.
  - error is tied to 0.

## Test plan
- Reset: hold RST=0 for 3 cycles -> all outputs at their reset values; en_read=0.
- Straight path: 15 x right then 15 x down, pos_ready=1, then complete_read=1 -> 31 coordinates from (0,0) to (15,15); steps=30; done=1; at_goal=1; 30 en_read pulses.
- Backpressure: pos_ready toggles 1/0 on a 4-move path -> each coordinate held stable while pos_ready=0; no duplicates or drops; en_read count=4.
- Empty list: complete_read=1 before start -> single (0,0); steps=0; done=1; at_goal=0.
- Bounds with macro: first Move=00 (up) -> error=1; done=1; position (0,0); no en_read. Without the macro, the same stimulus emits (0,15) and error=0.
- Mid-run reset: assert RST after 3 moves -> outputs return to reset values within the same cycle. A new start then replays from (0,0).
